// File: rtl/dram_cmd_responder.sv
// Device-side responder for the cmd_req/cmd_ack four-phase handshake: tracks the open row
// per bank, enforces command latencies and drives encoded ids and strobes to the array model.
module dram_cmd_responder #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int T_RCD        = 3,
    parameter int T_CAS        = 2,
    parameter int T_WR         = 2,
    parameter int T_RP         = 3,
    localparam int BW = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1,
    localparam int RW = (NUM_OF_ROWS  > 1) ? $clog2(NUM_OF_ROWS)  : 1,
    localparam int CW = (NUM_OF_COLS  > 1) ? $clog2(NUM_OF_COLS)  : 1
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    cmd_req,
    input  logic [1:0]              cmd,
    input  logic [NUM_OF_BANKS-1:0] bank_sel,
    input  logic [NUM_OF_ROWS-1:0]  row_sel,
    input  logic [NUM_OF_COLS-1:0]  col_sel,
    output logic                    cmd_ack,
    output logic                    cmd_err,
    output logic [NUM_OF_BANKS-1:0] bank_open,
    output logic [BW-1:0]           bank_id,
    output logic [RW-1:0]           row_id,
    output logic [CW-1:0]           col_id,
    output logic                    array_en,
    output logic                    bank_rw,
    output logic                    buf_rw,
    output logic                    row_stb
);

    localparam int T_MAX_A = (T_RCD > T_CAS) ? T_RCD : T_CAS;
    localparam int T_MAX_B = (T_WR > T_RP) ? T_WR : T_RP;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int CNT_W   = $clog2(T_MAX + 2);

    typedef enum logic [2:0] {IDLE, DECODE, WAIT, ACK, RELEASE} state_t;
    typedef enum logic [1:0] {CMD_ACT = 2'b00, CMD_RD = 2'b01, CMD_WR = 2'b10, CMD_PRE = 2'b11} cmd_t;

    state_t           state;
    cmd_t             cmd_q;
    logic             sel_ok_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt;
    logic [RW-1:0]    open_row [NUM_OF_BANKS];

    logic [BW-1:0]    bank_enc;
    logic [RW-1:0]    row_enc;
    logic [CW-1:0]    col_enc;
    logic             dec_err;
    logic [CNT_W-1:0] wait_load;

    always_comb begin
        bank_enc = '0;
        for (int i = 0; i < NUM_OF_BANKS; i++)
            if (bank_sel[i]) bank_enc = BW'(i);
    end

    always_comb begin
        row_enc = '0;
        for (int i = 0; i < NUM_OF_ROWS; i++)
            if (row_sel[i]) row_enc = RW'(i);
    end

    always_comb begin
        col_enc = '0;
        for (int i = 0; i < NUM_OF_COLS; i++)
            if (col_sel[i]) col_enc = CW'(i);
    end

    // Error priority: malformed selects, then bank-state conflicts for the decoded bank.
    always_comb begin
        dec_err = 1'b0;
        if (!sel_ok_q) begin
            dec_err = 1'b1;
        end else begin
            case (cmd_q)
                CMD_ACT:        dec_err = bank_open[bank_id];
                CMD_RD, CMD_WR: dec_err = !bank_open[bank_id] || (open_row[bank_id] != row_id);
                default:        dec_err = 1'b0;
            endcase
        end
    end

    // WAIT exits when it sees 1, so loading latency+1 lands cmd_ack at latency+2 edges
    // after the request was sampled; an error loads 1 and acks two edges after sampling.
    always_comb begin
        wait_load = CNT_W'(1);
        if (!dec_err) begin
            case (cmd_q)
                CMD_ACT: wait_load = CNT_W'(T_RCD + 1);
                CMD_RD:  wait_load = CNT_W'(T_CAS + 1);
                CMD_WR:  wait_load = CNT_W'(T_WR + 1);
                default: wait_load = CNT_W'(T_RP + 1);
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state     <= IDLE;
            cmd_q     <= CMD_ACT;
            sel_ok_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt       <= '0;
            cmd_ack   <= 1'b0;
            cmd_err   <= 1'b0;
            bank_open <= '0;
            bank_id   <= '0;
            row_id    <= '0;
            col_id    <= '0;
            array_en  <= 1'b0;
            bank_rw   <= 1'b0;
            buf_rw    <= 1'b0;
            row_stb   <= 1'b0;
            for (int i = 0; i < NUM_OF_BANKS; i++) open_row[i] <= '0;
        end else begin
            array_en <= 1'b0;
            row_stb  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_req) begin
                        cmd_q    <= cmd_t'(cmd);
                        bank_id  <= bank_enc;
                        row_id   <= row_enc;
                        col_id   <= col_enc;
                        sel_ok_q <= $onehot(bank_sel) && $onehot(row_sel) && $onehot(col_sel);
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    if (!cmd_req) begin
                        state <= IDLE;
                    end else begin
                        err_q <= dec_err;
                        cnt   <= wait_load;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!cmd_req) begin
                        state <= IDLE;
                    end else if (cnt == CNT_W'(1)) begin
                        state   <= ACK;
                        cmd_ack <= 1'b1;
                        cmd_err <= err_q;
                        if (!err_q) begin
                            case (cmd_q)
                                CMD_ACT: begin
                                    bank_open[bank_id] <= 1'b1;
                                    open_row[bank_id]  <= row_id;
                                    row_stb            <= 1'b1;
                                    buf_rw             <= 1'b1;
                                end
                                CMD_RD: begin
                                    array_en <= 1'b1;
                                    bank_rw  <= 1'b0;
                                end
                                CMD_WR: begin
                                    array_en <= 1'b1;
                                    bank_rw  <= 1'b1;
                                end
                                default: begin
                                    // Closing an already closed bank is a legal no-op.
                                    if (bank_open[bank_id]) begin
                                        bank_open[bank_id] <= 1'b0;
                                        row_stb            <= 1'b1;
                                        buf_rw             <= 1'b0;
                                    end
                                end
                            endcase
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ACK: begin
                    if (!cmd_req) begin
                        cmd_ack <= 1'b0;
                        cmd_err <= 1'b0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dram_cmd_responder.md
Name: dram_cmd_responder

Overview:
- Device-side responder for the controller's cmd_req/cmd_ack command handshake.
- Takes the controller's one-hot bank/row/col selects and 2-bit command, and tracks the open row per bank.
- Enforces ACTIVATE/READ/WRITE/PRECHARGE timing latencies and drives encoded ids and strobes to the DRAM array model.
- Replaces the fixed-delay ack model in the controller bench, and becomes the front end of the DRAM model.

Parameters:
- NUM_OF_BANKS, 8, bank count; width of bank_sel.
- NUM_OF_ROWS, 128, rows per bank; width of row_sel.
- NUM_OF_COLS, 8, columns per row; width of col_sel.
- T_RCD, 3, cycles of ACTIVATE latency (min 1).
- T_CAS, 2, cycles of READ latency (min 1).
- T_WR, 2, cycles of WRITE latency (min 1).
- T_RP, 3, cycles of PRECHARGE latency (min 1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_b  in  1  reset, asynchronous, active-high: 1 = in reset.
- cmd_req  in  1  command request, four-phase handshake.
- cmd  in  2  command: 00 ACTIVATE, 01 READ, 10 WRITE, 11 PRECHARGE.
- bank_sel  in  NUM_OF_BANKS  one-hot bank select.
- row_sel  in  NUM_OF_ROWS  one-hot row select.
- col_sel  in  NUM_OF_COLS  one-hot column select.
- cmd_ack  out  1  command acknowledge.
- cmd_err  out  1  error flag; valid while cmd_ack=1.
- bank_open  out  NUM_OF_BANKS  per-bank open-row flag.
- bank_id  out  clog2(NUM_OF_BANKS)  encoded bank of the latched command.
- row_id  out  clog2(NUM_OF_ROWS)  encoded row.
- col_id  out  clog2(NUM_OF_COLS)  encoded column.
- array_en  out  1  one-cycle array access strobe.
- bank_rw  out  1  1 = write, 0 = read; qualified by array_en.
- buf_rw  out  1  row-buffer direction: 1 = load row (ACTIVATE), 0 = write-back (PRECHARGE); qualified by row_stb.
- row_stb  out  1  one-cycle row open/close strobe.

Behaviour:
- Reset (rst_b=1, async): all outputs 0 and all banks closed. This applies mid-operation too: any in-flight command is dropped and the state returns to IDLE.
- States: IDLE, DECODE, WAIT, ACK, RELEASE.
- IDLE: cmd_req sampled 1 → latch cmd and all selects; encode ids; go to DECODE. Ids hold until the next latch.
- DECODE (1 cycle):
  - Check for errors, in priority order:
    - any select not exactly one-hot;
    - ACTIVATE to an open bank;
    - READ/WRITE to a closed bank;
    - READ/WRITE whose row differs from that bank's open row.
  - Error → go to ACK with cmd_err=1; no bank state change, no strobes.
  - No error → load the counter with the command's latency (T_RCD/T_CAS/T_WR/T_RP) and go to WAIT.
- WAIT: decrement the counter; on reaching 1, go to ACK.
- ACK timing:
  - cmd_ack rises exactly latency+2 edges after the edge that sampled cmd_req.
  - An error acks at edge 2.
- ACK entry side effects, registered in the same edge as cmd_ack rising, valid commands only:
  - ACTIVATE: bank_open[b]=1, store row, row_stb=1, buf_rw=1.
  - PRECHARGE: row_stb=1, buf_rw=0, bank_open[b]=0. PRECHARGE of an already closed bank is legal; it acks with no strobe.
  - READ: array_en=1, bank_rw=0.
  - WRITE: array_en=1, bank_rw=1.
  - Strobes are high for exactly one cycle.
- ACK: hold cmd_ack=1 and cmd_err until cmd_req is sampled 0, then go to RELEASE with cmd_ack=0 and cmd_err=0.
- RELEASE: 1 cycle, then IDLE. cmd_req=1 seen in RELEASE is ignored. A new request is accepted only in IDLE, so back-to-back requests have at least one idle gap.
- Abort: cmd_req falls during DECODE or WAIT → return to IDLE. No side effects, no ack, cmd_err stays 0.
- Inputs other than cmd_req are ignored outside IDLE.
- Open-row storage: NUM_OF_BANKS × clog2(NUM_OF_ROWS) registers.

Test Plan:
- Reset, then ACTIVATE bank_sel=8'h04, row_sel=bit 37 → cmd_ack at edge 5; row_stb one cycle, buf_rw=1; bank_open=8'h04; bank_id=2, row_id=37.
- After that ACTIVATE:
  - WRITE bank 2, row 37, col_sel=8'h80 → ack at edge 4; array_en pulse; bank_rw=1; col_id=7.
  - READ of the same address → ack at edge 4; array_en pulse; bank_rw=0.
- READ to closed bank 5 → ack at edge 2, cmd_err=1, no array_en. Likewise READ bank 2 row 36 → cmd_err=1. Likewise bank_sel=8'h06 → cmd_err=1, bank_open unchanged.
- PRECHARGE bank 2 → ack at edge 5, row_stb with buf_rw=0, bank_open=0. A second PRECHARGE acks with cmd_err=0 and no strobe.
- Abort and reset:
  - Drop cmd_req during WAIT of an ACTIVATE → no ack; bank_open unchanged; the next request is serviced normally.
  - Assert rst_b during WAIT → cmd_ack=0 immediately, bank_open=0.
- Handshake: hold cmd_req high 10 cycles past ack → cmd_ack stays 1. Drop it → cmd_ack=0 next edge. A fresh request gets its ack after the RELEASE and IDLE gap.
